// File: rtl/sc_micro_sequencer.sv
// Microprogram sequencer: selects the next control-store address from COND, flags and IR decode.
// uPC, decode flag, trap flag and microcycle counter are all registered (one-cycle latency, no comb in->out).
module sc_micro_sequencer #(
  parameter int unsigned              UADDR_WIDTH = 11,
  parameter logic [UADDR_WIDTH-1:0]   RESET_UADDR = 11'h000,
  parameter logic [UADDR_WIDTH-1:0]   TRAP_UADDR  = 11'h7FF,
  parameter int unsigned              CNT_WIDTH   = 16
) (
  input  logic                   SC_MicroSeq_CLOCK_50,
  input  logic                   SC_MicroSeq_Reset_InHigh,
  input  logic [2:0]             SC_MicroSeq_COND,
  input  logic [UADDR_WIDTH-1:0] SC_MicroSeq_JUMPADDR,
  input  logic [1:0]             SC_MicroSeq_OP,
  input  logic [5:0]             SC_MicroSeq_OP3,
  input  logic                   SC_MicroSeq_BIT13,
  input  logic                   SC_MicroSeq_N,
  input  logic                   SC_MicroSeq_Z,
  input  logic                   SC_MicroSeq_V,
  input  logic                   SC_MicroSeq_C,
  input  logic                   SC_MicroSeq_Hold_InHigh,
  output logic [UADDR_WIDTH-1:0] SC_MicroSeq_uPC_Out,
  output logic                   SC_MicroSeq_Decode_OutHigh,
  output logic                   SC_MicroSeq_Trap_OutHigh,
  output logic [CNT_WIDTH-1:0]   SC_MicroSeq_CycleCount_Out
);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_TRAP = 1'b1} state_t;

  state_t                 state_q;
  logic [UADDR_WIDTH-1:0] upc_q;
  logic [UADDR_WIDTH-1:0] upc_d;
  logic [UADDR_WIDTH-1:0] upc_inc;
  logic [UADDR_WIDTH-1:0] decode_addr;
  logic                   decode_q;
  logic                   decode_d;
  logic                   trap_q;
  logic                   illegal;
  logic [CNT_WIDTH-1:0]   cnt_q;

  // Decode target format is fixed at 11 bits: {1, OP, OP3, 00}.
  assign decode_addr = {1'b1, SC_MicroSeq_OP, SC_MicroSeq_OP3, 2'b00};
  assign upc_inc     = upc_q + 1'b1;
  assign illegal     = (SC_MicroSeq_COND == 3'b111) && (SC_MicroSeq_OP == 2'b00) &&
                       (SC_MicroSeq_OP3[5:3] == 3'b000);

  always_comb begin
    upc_d    = upc_inc;
    decode_d = 1'b0;
    case (SC_MicroSeq_COND)
      3'b001: if (SC_MicroSeq_N)     upc_d = SC_MicroSeq_JUMPADDR;
      3'b010: if (SC_MicroSeq_Z)     upc_d = SC_MicroSeq_JUMPADDR;
      3'b011: if (SC_MicroSeq_V)     upc_d = SC_MicroSeq_JUMPADDR;
      3'b100: if (SC_MicroSeq_C)     upc_d = SC_MicroSeq_JUMPADDR;
      3'b101: if (SC_MicroSeq_BIT13) upc_d = SC_MicroSeq_JUMPADDR;
      3'b110: upc_d = SC_MicroSeq_JUMPADDR;
      3'b111: begin
        upc_d    = decode_addr;
        decode_d = 1'b1;
      end
      default: upc_d = upc_inc;
    endcase
  end

  always_ff @(posedge SC_MicroSeq_CLOCK_50) begin
    if (SC_MicroSeq_Reset_InHigh) begin
      state_q  <= ST_RUN;
      upc_q    <= RESET_UADDR;
      decode_q <= 1'b0;
      trap_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!SC_MicroSeq_Hold_InHigh) begin
            cnt_q <= cnt_q + 1'b1;
            if (illegal) begin
              state_q  <= ST_TRAP;
              upc_q    <= TRAP_UADDR;
              decode_q <= 1'b0;
              trap_q   <= 1'b1;
            end else begin
              upc_q    <= upc_d;
              decode_q <= decode_d;
            end
          end
        end
        ST_TRAP: begin
          // Parked until reset; all inputs ignored.
          upc_q    <= TRAP_UADDR;
          decode_q <= 1'b0;
          trap_q   <= 1'b1;
        end
        default: begin
          state_q <= ST_RUN;
          upc_q   <= RESET_UADDR;
        end
      endcase
    end
  end

  assign SC_MicroSeq_uPC_Out        = upc_q;
  assign SC_MicroSeq_Decode_OutHigh = decode_q;
  assign SC_MicroSeq_Trap_OutHigh   = trap_q;
  assign SC_MicroSeq_CycleCount_Out = cnt_q;

endmodule

// File: tb/tb_sc_micro_sequencer.sv
// Directed bench for sc_micro_sequencer: hand-computed microaddress/flag/count expectations per scenario.
module tb_sc_micro_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  cond = 3'b000;
  logic [10:0] jaddr = 11'h000;
  logic [1:0]  op = 2'b00;
  logic [5:0]  op3 = 6'b000000;
  logic        bit13 = 1'b0;
  logic        fn = 1'b0, fz = 1'b0, fv = 1'b0, fc = 1'b0;
  logic        hold = 1'b0;
  logic [10:0] upc;
  logic        dec;
  logic        trap;
  logic [15:0] cnt;

  int total = 0;
  int bad = 0;
  logic [15:0] exp_cnt = 16'd0;

  always #10 clk = ~clk;

  sc_micro_sequencer dut (
    .SC_MicroSeq_CLOCK_50       (clk),
    .SC_MicroSeq_Reset_InHigh   (rst),
    .SC_MicroSeq_COND           (cond),
    .SC_MicroSeq_JUMPADDR       (jaddr),
    .SC_MicroSeq_OP             (op),
    .SC_MicroSeq_OP3            (op3),
    .SC_MicroSeq_BIT13          (bit13),
    .SC_MicroSeq_N              (fn),
    .SC_MicroSeq_Z              (fz),
    .SC_MicroSeq_V              (fv),
    .SC_MicroSeq_C              (fc),
    .SC_MicroSeq_Hold_InHigh    (hold),
    .SC_MicroSeq_uPC_Out        (upc),
    .SC_MicroSeq_Decode_OutHigh (dec),
    .SC_MicroSeq_Trap_OutHigh   (trap),
    .SC_MicroSeq_CycleCount_Out (cnt)
  );

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; hold = 1'b0; cond = 3'b000;
    step();
    total++; if (upc !== 11'h000) begin bad++; $display("FAIL reset_upc got=%h want=000", upc); end
    total++; if (dec !== 1'b0) begin bad++; $display("FAIL reset_dec got=%b want=0", dec); end
    total++; if (trap !== 1'b0) begin bad++; $display("FAIL reset_trap got=%b want=0", trap); end
    total++; if (cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", cnt); end
    exp_cnt = 16'd0;
  endtask

  task automatic test_sequential();
    rst = 1'b0; cond = 3'b000;
    for (int i = 1; i <= 3; i++) begin
      step(); exp_cnt++;
      total++; if (upc !== 11'(i)) begin bad++; $display("FAIL seq_upc%0d got=%h want=%h", i, upc, 11'(i)); end
    end
    total++; if (cnt !== 16'd3) begin bad++; $display("FAIL seq_cnt got=%0d want=3", cnt); end
    total++; if (dec !== 1'b0) begin bad++; $display("FAIL seq_dec got=%b want=0", dec); end
  endtask

  task automatic test_cond_jump();
    cond = 3'b110; jaddr = 11'h010; step(); exp_cnt++;
    total++; if (upc !== 11'h010) begin bad++; $display("FAIL jmp_uncond got=%h want=010", upc); end
    cond = 3'b010; jaddr = 11'h123; fz = 1'b1; step(); exp_cnt++;
    total++; if (upc !== 11'h123) begin bad++; $display("FAIL jmp_z1 got=%h want=123", upc); end
    cond = 3'b110; jaddr = 11'h010; step(); exp_cnt++;
    cond = 3'b010; jaddr = 11'h123; fz = 1'b0; step(); exp_cnt++;
    total++; if (upc !== 11'h011) begin bad++; $display("FAIL jmp_z0 got=%h want=011", upc); end
    cond = 3'b101; jaddr = 11'h2AB; bit13 = 1'b1; step(); exp_cnt++;
    total++; if (upc !== 11'h2AB) begin bad++; $display("FAIL jmp_bit13 got=%h want=2AB", upc); end
    bit13 = 1'b0; step(); exp_cnt++;
    total++; if (upc !== 11'h2AC) begin bad++; $display("FAIL jmp_bit13_0 got=%h want=2AC", upc); end
    // N/V/C each taken with its own flag while the others are set to decoy values
    cond = 3'b001; jaddr = 11'h0A0; fn = 1'b1; fv = 1'b0; fc = 1'b0; step(); exp_cnt++;
    total++; if (upc !== 11'h0A0) begin bad++; $display("FAIL jmp_n got=%h want=0A0", upc); end
    cond = 3'b011; jaddr = 11'h0B0; step(); exp_cnt++;
    total++; if (upc !== 11'h0A1) begin bad++; $display("FAIL jmp_v0 got=%h want=0A1", upc); end
    fv = 1'b1; fn = 1'b0; step(); exp_cnt++;
    total++; if (upc !== 11'h0B0) begin bad++; $display("FAIL jmp_v1 got=%h want=0B0", upc); end
    cond = 3'b100; jaddr = 11'h0C0; fc = 1'b1; fv = 1'b0; step(); exp_cnt++;
    total++; if (upc !== 11'h0C0) begin bad++; $display("FAIL jmp_c got=%h want=0C0", upc); end
    fc = 1'b0;
    total++; if (cnt !== exp_cnt) begin bad++; $display("FAIL jmp_cnt got=%0d want=%0d", cnt, exp_cnt); end
  endtask

  task automatic test_decode();
    cond = 3'b111; op = 2'b10; op3 = 6'b000000; step(); exp_cnt++;
    total++; if (upc !== 11'h600) begin bad++; $display("FAIL dec_op10 got=%h want=600", upc); end
    total++; if (dec !== 1'b1) begin bad++; $display("FAIL dec_flag got=%b want=1", dec); end
    cond = 3'b000; step(); exp_cnt++;
    total++; if (upc !== 11'h601) begin bad++; $display("FAIL dec_next got=%h want=601", upc); end
    total++; if (dec !== 1'b0) begin bad++; $display("FAIL dec_clear got=%b want=0", dec); end
    cond = 3'b111; op = 2'b11; op3 = 6'b000000; step(); exp_cnt++;
    total++; if (upc !== 11'h700) begin bad++; $display("FAIL dec_op11 got=%h want=700", upc); end
    op = 2'b00; op3 = 6'b010101; step(); exp_cnt++;
    total++; if (upc !== 11'h454) begin bad++; $display("FAIL dec_op00_legal got=%h want=454", upc); end
    total++; if (trap !== 1'b0) begin bad++; $display("FAIL dec_legal_trap got=%b want=0", trap); end
  endtask

  task automatic test_hold();
    cond = 3'b111; op = 2'b10; op3 = 6'b000000; step(); exp_cnt++;
    // Illegal opcode presented under hold must neither trap nor move anything
    hold = 1'b1; op = 2'b00; op3 = 6'b000011;
    for (int i = 0; i < 2; i++) step();
    total++; if (upc !== 11'h600) begin bad++; $display("FAIL hold_illegal_upc got=%h want=600", upc); end
    total++; if (dec !== 1'b1) begin bad++; $display("FAIL hold_dec got=%b want=1", dec); end
    total++; if (trap !== 1'b0) begin bad++; $display("FAIL hold_trap got=%b want=0", trap); end
    hold = 1'b0; cond = 3'b110; jaddr = 11'h020; step(); exp_cnt++;
    hold = 1'b1; jaddr = 11'h055;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (upc !== 11'h020) begin bad++; $display("FAIL hold_upc%0d got=%h want=020", i, upc); end
    end
    total++; if (cnt !== exp_cnt) begin bad++; $display("FAIL hold_cnt got=%0d want=%0d", cnt, exp_cnt); end
    hold = 1'b0; step(); exp_cnt++;
    total++; if (upc !== 11'h055) begin bad++; $display("FAIL hold_release got=%h want=055", upc); end
    total++; if (cnt !== exp_cnt) begin bad++; $display("FAIL hold_release_cnt got=%0d want=%0d", cnt, exp_cnt); end
  endtask

  task automatic test_wrap();
    cond = 3'b110; jaddr = 11'h7FF; step(); exp_cnt++;
    total++; if (upc !== 11'h7FF || trap !== 1'b0) begin bad++; $display("FAIL wrap_at7ff got=%h/%b want=7FF/0", upc, trap); end
    cond = 3'b000; step(); exp_cnt++;
    total++; if (upc !== 11'h000) begin bad++; $display("FAIL wrap_upc got=%h want=000", upc); end
    total++; if (trap !== 1'b0) begin bad++; $display("FAIL wrap_trap got=%b want=0", trap); end
  endtask

  task automatic test_trap();
    cond = 3'b111; op = 2'b00; op3 = 6'b000101; step(); exp_cnt++;
    total++; if (upc !== 11'h7FF) begin bad++; $display("FAIL trap_upc got=%h want=7FF", upc); end
    total++; if (trap !== 1'b1) begin bad++; $display("FAIL trap_flag got=%b want=1", trap); end
    total++; if (dec !== 1'b0) begin bad++; $display("FAIL trap_dec got=%b want=0", dec); end
    total++; if (cnt !== exp_cnt) begin bad++; $display("FAIL trap_entry_cnt got=%0d want=%0d", cnt, exp_cnt); end
    cond = 3'b110; jaddr = 11'h050;
    for (int i = 0; i < 3; i++) step();
    hold = 1'b1; step(); hold = 1'b0; cond = 3'b111; op = 2'b10; step();
    total++; if (upc !== 11'h7FF) begin bad++; $display("FAIL trap_stuck got=%h want=7FF", upc); end
    total++; if (cnt !== exp_cnt) begin bad++; $display("FAIL trap_cnt_frozen got=%0d want=%0d", cnt, exp_cnt); end
    total++; if (trap !== 1'b1 || dec !== 1'b0) begin bad++; $display("FAIL trap_flags got=%b/%b want=1/0", trap, dec); end
  endtask

  task automatic test_reset_in_trap();
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (trap !== 1'b1 || upc !== 11'h7FF) begin bad++; $display("FAIL rst_pre_edge got=%b/%h want=1/7FF", trap, upc); end
    step(); exp_cnt = 16'd0;
    total++; if (upc !== 11'h000) begin bad++; $display("FAIL rst_trap_upc got=%h want=000", upc); end
    total++; if (trap !== 1'b0) begin bad++; $display("FAIL rst_trap_flag got=%b want=0", trap); end
    total++; if (cnt !== 16'd0) begin bad++; $display("FAIL rst_trap_cnt got=%0d want=0", cnt); end
    rst = 1'b0; cond = 3'b000; step(); exp_cnt++;
    total++; if (upc !== 11'h001 || cnt !== 16'd1) begin bad++; $display("FAIL rst_resume got=%h/%0d want=001/1", upc, cnt); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_cond_jump();
    test_decode();
    test_hold();
    test_wrap();
    test_trap();
    test_reset_in_trap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sc_micro_sequencer.md
# sc_micro_sequencer

Microprogram sequencer for the ARC-style microcoded datapath. It sits directly downstream of the instruction register. It consumes the IR decode fields (OP, OP3, BIT13) together with the current microword's COND/JUMP ADDR fields and the PSR flags. From these it produces the registered microaddress that indexes the control store. It also provides memory-wait hold, an illegal-opcode trap state and a microcycle counter.

## Interface
- UADDR_WIDTH, 11, microaddress width; the decode address format requires exactly 11.
- RESET_UADDR, 11'h000, microaddress loaded on reset.
- TRAP_UADDR, 11'h7FF, microaddress held while trapped. Its low bits are 11, so it is never a decode target.
- CNT_WIDTH, 16, microcycle counter width.

Ports:
- SC_MicroSeq_CLOCK_50  in  1  single clock; all state updates on the rising edge.
- SC_MicroSeq_Reset_InHigh  in  1  reset, synchronous, active-high.
- SC_MicroSeq_COND  in  3  branch condition field of the current microword.
- SC_MicroSeq_JUMPADDR  in  UADDR_WIDTH  jump target field of the current microword.
- SC_MicroSeq_OP  in  2  IR[31:30].
- SC_MicroSeq_OP3  in  6  IR[24:19]; bits [5:3] equal OP2.
- SC_MicroSeq_BIT13  in  1  IR[13].
- SC_MicroSeq_N, _Z, _V, _C  in  1 each  PSR condition flags.
- SC_MicroSeq_Hold_InHigh  in  1  memory not ready; freezes sequencing.
- SC_MicroSeq_uPC_Out  out  UADDR_WIDTH  current microaddress (register output).
- SC_MicroSeq_Decode_OutHigh  out  1  high for the cycle in which uPC_Out holds a decode-loaded address.
- SC_MicroSeq_Trap_OutHigh  out  1  high while in TRAP state.
- SC_MicroSeq_CycleCount_Out  out  CNT_WIDTH  number of executed (non-held) microcycles.

## Operation
- FSM states:
  - RUN: normal sequencing.
  - TRAP: halted at TRAP_UADDR.
- Reset puts the FSM in RUN.
- Next-address selection in RUN, when Hold=0. The COND field selects the next uPC:
  - 000: uPC+1.
  - 001: JUMPADDR if N, else uPC+1.
  - 010: JUMPADDR if Z, else uPC+1.
  - 011: JUMPADDR if V, else uPC+1.
  - 100: JUMPADDR if C, else uPC+1.
  - 101: JUMPADDR if BIT13, else uPC+1.
  - 110: JUMPADDR unconditionally.
  - 111: decode.
- Decode address is {1'b1, OP, OP3, 2'b00}.
- Illegal decode: COND=111 with OP=00 and OP3[5:3]=000 (UNIMP).
  - uPC loads TRAP_UADDR and the FSM enters TRAP.
  - Decode_OutHigh stays 0.
- uPC+1 is modulo 2^UADDR_WIDTH, so 0x7FF+1 = 0x000.
- Reaching 0x7FF by sequencing does not enter TRAP; only an illegal decode does.
- Decode_OutHigh is registered. It is 1 after a legal decode load and 0 after any other update. It is held unchanged during Hold.
- CycleCount increments by 1 on every RUN cycle with Hold=0, including the cycle that enters TRAP. It wraps at 2^CNT_WIDTH.
- Hold=1 in RUN freezes uPC, Decode_OutHigh and CycleCount. COND and flags are ignored, and no trap is evaluated.
- TRAP state:
  - uPC is fixed at TRAP_UADDR, CycleCount is frozen, and Trap_OutHigh=1.
  - COND, Hold and flags are ignored.
  - Only reset exits TRAP.
- Priority: Reset > TRAP state > Hold > COND selection.

## Timing
- Reset values, applied at the first rising edge with Reset=1:
  - uPC_Out = RESET_UADDR.
  - Decode_OutHigh = 0.
  - Trap_OutHigh = 0.
  - CycleCount_Out = 0.
  - FSM = RUN.
- Reset asserted mid-operation, including in TRAP, takes effect at the next edge and overrides everything.
- Reset only takes effect at a clock edge; outputs keep their values between the assertion of Reset and that edge.
- Latency: inputs are sampled at edge k and the new uPC is visible after edge k. Each microinstruction takes one cycle; there is no combinational path from inputs to outputs.
- Hold is sampled per edge. Releasing Hold resumes using the COND/flags present at that edge.
- Flag or BIT13 changes in the same cycle as a conditional COND use the sampled value at the edge.

## Test plan
- Reset then 3 cycles with COND=000 and Hold=0 -> uPC 0x000, 0x001, 0x002, 0x003; CycleCount=3; Decode=0.
- Conditional jumps:
  - uPC=0x010, COND=010, JUMPADDR=0x123, Z=1 -> uPC=0x123.
  - Repeat with Z=0 -> uPC=0x011.
  - COND=101 with BIT13=1 -> uPC=JUMPADDR.
- Decode:
  - COND=111, OP=10, OP3=000000 -> uPC=0x600, Decode=1.
  - Next cycle COND=000 -> uPC=0x601, Decode=0.
  - OP=11, OP3=000000 -> uPC=0x700.
- Illegal decode: COND=111, OP=00, OP3=000xxx -> uPC=0x7FF, Trap=1, Decode=0. Later COND=110 with JUMPADDR=0x050 -> uPC remains 0x7FF and CycleCount frozen.
- Hold: uPC=0x020, Hold=1 for 4 cycles with COND=110 -> uPC=0x020 and CycleCount unchanged. Release Hold -> uPC=JUMPADDR.
- Wrap and reset:
  - uPC=0x7FF in RUN (reached via JUMPADDR=0x7FF) with COND=000 -> uPC=0x000, Trap=0.
  - Reset asserted in TRAP -> next edge: uPC=0x000, Trap=0, CycleCount=0.
